// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: IF/ID, ID/EX and EX/MEM register-use
// information in, pipeline enables and stall status out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [1:0]       id_tuse_rs;
    logic [1:0]       id_tuse_rt;
    logic             id_md_use;
    logic [4:0]       ex_wa;
    logic [1:0]       ex_tnew;
    logic [4:0]       mem_wa;
    logic [1:0]       mem_tnew;
    logic             ex_md_start;
    logic             ex_md_div;
    logic             cnt_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_clr;
    logic             md_busy;
    logic             stall;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: supplies register-use info, consumes the enables.
    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use,
               ex_wa, ex_tnew, mem_wa, mem_tnew,
               ex_md_start, ex_md_div, cnt_clr,
        input  pc_en, if_id_en, id_ex_clr, md_busy, stall, stall_cycles
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use,
               ex_wa, ex_tnew, mem_wa, mem_tnew,
               ex_md_start, ex_md_div, cnt_clr,
        output pc_en, if_id_en, id_ex_clr, md_busy, stall, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall controller for the five-stage pipeline. Compares operand need time
// (tuse) of the IF/ID instruction against result ready time (tnew) of the
// instructions in ID/EX and EX/MEM, and tracks the multi-cycle mul/div unit.
// The stall decision is combinational so the freeze and bubble take effect
// at the very next edge.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hc
);
    localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);
    localparam logic [MD_W-1:0] MULT_LD = MD_W'(MULT_CYC);
    localparam logic [MD_W-1:0] DIV_LD  = MD_W'(DIV_CYC);

    logic [MD_W-1:0]  md_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             rs_haz;
    logic             rt_haz;
    logic             md_busy_i;
    logic             stall_i;

    // Register hazards: a source is stalled while the producer's result
    // arrives later than the consumer needs it. $0 never matches, and a
    // tuse of 3 (unused) can never be below a 2-bit tnew.
    always_comb begin
        rs_haz = (hc.id_rs != 5'd0) &&
                 (((hc.id_rs == hc.ex_wa)  && (hc.id_tuse_rs < hc.ex_tnew)) ||
                  ((hc.id_rs == hc.mem_wa) && (hc.id_tuse_rs < hc.mem_tnew)));
        rt_haz = (hc.id_rt != 5'd0) &&
                 (((hc.id_rt == hc.ex_wa)  && (hc.id_tuse_rt < hc.ex_tnew)) ||
                  ((hc.id_rt == hc.mem_wa) && (hc.id_tuse_rt < hc.mem_tnew)));
        // The unit counts as busy already in the cycle the op is in EX.
        md_busy_i = hc.ex_md_start || (md_cnt != '0);
        stall_i   = rs_haz || rt_haz || (hc.id_md_use && md_busy_i);
    end

    assign hc.stall        = stall_i;
    assign hc.pc_en        = ~stall_i;
    assign hc.if_id_en     = ~stall_i;
    assign hc.id_ex_clr    = stall_i;
    assign hc.md_busy      = md_busy_i;
    assign hc.stall_cycles = stall_cnt;

    // Mul/div busy counter: a new op (re)loads, otherwise count down to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (hc.ex_md_start) begin
            md_cnt <= hc.ex_md_div ? DIV_LD : MULT_LD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hc.cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a reference model.
module tb_hazard_ctrl;
    localparam int MULT = 5;
    localparam int DIV  = 10;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    hazard_ctrl_if #(.CNT_W(CW)) hif ();

    hazard_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hc    (hif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: busy window from the cycle index of the last mul/div
    // issue, and a plain integer stall tally.
    int cyc = 0;
    int t0 = 0;
    int len = 0;
    bit have_t0 = 1'b0;
    int sc = 0;

    function automatic bit reg_haz(input logic [4:0] r, input logic [1:0] tu,
                                   input logic [4:0] ewa, input logic [1:0] etn,
                                   input logic [4:0] mwa, input logic [1:0] mtn);
        int need, ready_e, ready_m;
        need = tu; ready_e = etn; ready_m = mtn;
        if (r == 0) return 1'b0;
        return ((r == ewa) && (need < ready_e)) || ((r == mwa) && (need < ready_m));
    endfunction

    function automatic bit m_busy();
        return hif.ex_md_start || (have_t0 && (cyc - t0) <= len);
    endfunction

    function automatic bit m_stall();
        return reg_haz(hif.id_rs, hif.id_tuse_rs, hif.ex_wa, hif.ex_tnew, hif.mem_wa, hif.mem_tnew) ||
               reg_haz(hif.id_rt, hif.id_tuse_rt, hif.ex_wa, hif.ex_tnew, hif.mem_wa, hif.mem_tnew) ||
               (hif.id_md_use && m_busy());
    endfunction

    // Model state advance at each edge (and asynchronous reset).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_t0 <= 1'b0;
            sc      <= 0;
        end else begin
            if (hif.cnt_clr) sc <= 0;
            else if (m_stall() && sc < SAT) sc <= sc + 1;
            if (hif.ex_md_start) begin
                t0      <= cyc;
                len     <= hif.ex_md_div ? DIV : MULT;
                have_t0 <= 1'b1;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        bit s;
        s = m_stall();
        check("cmp_stall",     int'(hif.stall),        int'(s));
        check("cmp_pc_en",     int'(hif.pc_en),        int'(!s));
        check("cmp_if_id_en",  int'(hif.if_id_en),     int'(!s));
        check("cmp_id_ex_clr", int'(hif.id_ex_clr),    int'(s));
        check("cmp_md_busy",   int'(hif.md_busy),      int'(m_busy()));
        check("cmp_stall_cyc", int'(hif.stall_cycles), sc);
    end

    task automatic idle();
        hif.id_rs = 0; hif.id_rt = 0; hif.id_tuse_rs = 3; hif.id_tuse_rt = 3;
        hif.id_md_use = 0; hif.ex_wa = 0; hif.ex_tnew = 0; hif.mem_wa = 0;
        hif.mem_tnew = 0; hif.ex_md_start = 0; hif.ex_md_div = 0; hif.cnt_clr = 0;
    endtask

    // Advance to the next drive point (just after the rising edge).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        idle(); hif.cnt_clr = 1; step(); hif.cnt_clr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 0;
        #12;
        check("rst_pc_en", int'(hif.pc_en), 1);
        check("rst_stall", int'(hif.stall), 0);
        check("rst_busy",  int'(hif.md_busy), 0);
        check("rst_cnt",   int'(hif.stall_cycles), 0);
        step(); rst_n = 1; step();

        // Load-use: one stall cycle, then release as the load reaches MEM.
        clear_cnt();
        hif.id_rs = 8; hif.id_tuse_rs = 1; hif.ex_wa = 8; hif.ex_tnew = 2;
        @(negedge clk);
        check("lu_stall", int'(hif.stall), 1);
        check("lu_if_id_en", int'(hif.if_id_en), 0);
        check("lu_id_ex_clr", int'(hif.id_ex_clr), 1);
        step();
        hif.ex_wa = 0; hif.ex_tnew = 0; hif.mem_wa = 8; hif.mem_tnew = 1;
        @(negedge clk);
        check("lu_release", int'(hif.stall), 0);
        check("lu_cnt", int'(hif.stall_cycles), 1);
        step();

        // $0 and unused operand never stall.
        idle(); hif.id_rt = 0; hif.ex_wa = 0; hif.ex_tnew = 2; hif.id_tuse_rt = 0;
        @(negedge clk); check("r0_nostall", int'(hif.stall), 0);
        step();
        idle(); hif.id_rs = 5; hif.ex_wa = 5; hif.ex_tnew = 2; hif.id_tuse_rs = 3;
        @(negedge clk); check("tuse3_nostall", int'(hif.stall), 0);
        step();

        // Branch behind load: two stall cycles.
        idle(); hif.id_rs = 9; hif.id_tuse_rs = 0; hif.ex_wa = 9; hif.ex_tnew = 2;
        @(negedge clk); check("br_stall0", int'(hif.stall), 1);
        step();
        hif.ex_wa = 0; hif.ex_tnew = 0; hif.mem_wa = 9; hif.mem_tnew = 1;
        @(negedge clk); check("br_stall1", int'(hif.stall), 1);
        step();
        hif.mem_wa = 0; hif.mem_tnew = 0;
        @(negedge clk); check("br_release", int'(hif.stall), 0);
        step();

        // Divide then multiply with a dependent md instruction held in ID.
        for (int op = 0; op < 2; op++) begin
            int n;
            n = (op == 0) ? DIV : MULT;
            idle(); hif.id_md_use = 1; hif.ex_md_start = 1; hif.ex_md_div = (op == 0);
            for (int k = 0; k <= n + 1; k++) begin
                @(negedge clk);
                check(op == 0 ? "div_window" : "mul_window", int'(hif.stall), int'(k <= n));
                step();
                hif.ex_md_start = 0; hif.ex_md_div = 0;
            end
        end

        // Asynchronous reset in the middle of a divide (counter at 7).
        clear_cnt();
        hif.id_md_use = 1; hif.ex_md_start = 1; hif.ex_md_div = 1;
        step(); hif.ex_md_start = 0; hif.ex_md_div = 0;
        step(); step(); step();
        #2 rst_n = 0;
        #1;
        check("arst_busy", int'(hif.md_busy), 0);
        check("arst_cnt", int'(hif.stall_cycles), 0);
        check("arst_pc_en", int'(hif.pc_en), 1);
        step(); rst_n = 1; idle(); step();

        // Saturation, then clear together with an active stall.
        clear_cnt();
        hif.id_rs = 8; hif.id_tuse_rs = 1; hif.ex_wa = 8; hif.ex_tnew = 2;
        repeat (20) step();
        @(negedge clk); check("sat_cnt", int'(hif.stall_cycles), SAT);
        step();
        hif.cnt_clr = 1;
        step(); hif.cnt_clr = 0; idle();
        @(negedge clk); check("clr_cnt", int'(hif.stall_cycles), 0);
        step();

        // Randomized traffic; small register range makes matches common.
        for (int i = 0; i < 600; i++) begin
            hif.id_rs       = 5'($urandom_range(0, 3));
            hif.id_rt       = 5'($urandom_range(0, 3));
            hif.id_tuse_rs  = 2'($urandom_range(0, 3));
            hif.id_tuse_rt  = 2'($urandom_range(0, 3));
            hif.ex_wa       = 5'($urandom_range(0, 3));
            hif.ex_tnew     = 2'($urandom_range(0, 3));
            hif.mem_wa      = 5'($urandom_range(0, 3));
            hif.mem_tnew    = 2'($urandom_range(0, 3));
            hif.id_md_use   = ($urandom_range(0, 3) == 0);
            hif.ex_md_start = ($urandom_range(0, 11) == 0);
            hif.ex_md_div   = $urandom_range(0, 1) != 0;
            hif.cnt_clr     = ($urandom_range(0, 24) == 0);
            if (i == 300) begin
                #2 rst_n = 0; #1 rst_n = 1;
            end
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall controller for the five-stage MIPS datapath. It compares the register-use requirements of the instruction held in IF/ID against the pending writes in ID/EX and EX/MEM. It also tracks the multi-cycle multiply/divide unit. When a hazard exists, it freezes PC and IF/ID (drives their `en` low) and injects a bubble into ID/EX for exactly as long as the hazard lasts.

## Interface

Parameters:
- `MULT_CYC`, default 5: busy cycles after a mult/multu leaves EX.
- `DIV_CYC`, default 10: busy cycles after a div/divu leaves EX.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `id_rs`, `id_rt`, input, 5 each: source registers of the instruction in IF/ID.
- `id_tuse_rs`, `id_tuse_rt`, input, 2 each: cycles until the operand is needed. 0 = ID (branch/jr compare), 1 = EX, 2 = MEM (store data), 3 = unused.
- `id_md_use`, input, 1: the IF/ID instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `ex_wa`, input, 5: destination register of the ID/EX instruction (0 = none).
- `ex_tnew`, input, 2: cycles until the ID/EX result is forwardable.
- `mem_wa`, input, 5: destination register of the EX/MEM instruction (0 = none).
- `mem_tnew`, input, 2: cycles until the EX/MEM result is forwardable.
- `ex_md_start`, input, 1: the ID/EX instruction is mult/multu/div/divu.
- `ex_md_div`, input, 1: qualifies `ex_md_start`. 1 = div/divu.
- `cnt_clr`, input, 1: synchronous clear of `stall_cycles`.
- `pc_en`, output, 1: PC write enable.
- `if_id_en`, output, 1: IF/ID `en`.
- `id_ex_clr`, output, 1: synchronous clear of ID/EX (bubble).
- `md_busy`, output, 1: the multiply/divide unit is occupied.
- `stall`, output, 1: a hazard stall is active this cycle.
- `stall_cycles`, output, `CNT_W`: saturating count of stalled cycles.

## Operation

- Register hazard on rs:
  - Asserted when `id_rs != 0` and either of the following holds:
  - (`id_rs == ex_wa` and `id_tuse_rs < ex_tnew`), or
  - (`id_rs == mem_wa` and `id_tuse_rs < mem_tnew`).
- Register hazard on rt: same rule using `id_rt` and `id_tuse_rt`.
- A tuse of 3 never stalls, because 3 is not less than any 2-bit tnew.
- `ex_wa == 0` or `mem_wa == 0` never matches, because the source-register check excludes 0.
- MD hazard = `id_md_use & md_busy`.
- `stall` = rs hazard | rt hazard | MD hazard. This is purely combinational from the current inputs and state.
- `pc_en = if_id_en = ~stall`; `id_ex_clr = stall`.
- Multiply/divide busy counter (`md_cnt`, width sized to hold `DIV_CYC`):
  - At a clock edge with `ex_md_start = 1`, it loads `DIV_CYC` if `ex_md_div`, else `MULT_CYC`. This load takes priority over decrement, so a start while already busy reloads the counter.
  - Otherwise, if nonzero, it decrements by 1.
  - `md_busy = ex_md_start | (md_cnt != 0)`.
- Stall counter:
  - `cnt_clr` has priority and sets it to 0.
  - Otherwise it increments when `stall = 1`.
  - It holds at all-ones (saturates) and does not wrap.
- Reset (`rst_n = 0`, asynchronous, any time, including mid-divide):
  - `md_cnt = 0` and `stall_cycles = 0`.
  - With idle inputs, the outputs are `pc_en = 1`, `if_id_en = 1`, `id_ex_clr = 0`, `stall = 0`, `md_busy = 0`.

## Timing

- Stall decision latency: 0 cycles. Outputs respond combinationally within the same cycle, so IF/ID holds and ID/EX receives a bubble at the very next edge.
- Load-use case:
  - Load in ID/EX has `ex_tnew = 2`; a consumer with tuse 1 stalls 1 cycle.
  - The load then sits in EX/MEM with `mem_tnew = 1`, so 1 < 1 is false and the stall releases.
- Branch after load: tuse 0 stalls 2 cycles (tnew 2, then tnew 1).
- Branch after ALU: `ex_tnew = 1`, so 1 cycle.
- Mult issued in cycle t (`ex_md_start` high in t):
  - `md_busy` is high in t through t+`MULT_CYC`, i.e. `MULT_CYC`+1 cycles.
  - A dependent mfhi in ID is released in cycle t+`MULT_CYC`+1.
- `stall_cycles` updates one edge after the stalled cycle.

## Test plan

- Reset: assert `rst_n = 0` mid-divide with `md_cnt = 7`, then release. Required: `md_cnt = 0`, `md_busy = 0`, `stall_cycles = 0`, `pc_en = 1`, all immediately (asynchronously).
- Load-use: `ex_wa = 8`, `ex_tnew = 2`, `id_rs = 8`, `id_tuse_rs = 1` for one cycle, then `mem_wa = 8`, `mem_tnew = 1`. Required: exactly 1 cycle with `stall = 1`, `if_id_en = 0`, `id_ex_clr = 1`; `stall_cycles` goes to 1.
- Register $0 and unused operands:
  - `id_rt = 0`, `ex_wa = 0`, `ex_tnew = 2`, `id_tuse_rt = 0`: no stall.
  - `id_rs = 5`, `ex_wa = 5`, `id_tuse_rs = 3`: no stall.
- Branch: `id_tuse_rs = 0` behind a load (`ex_tnew = 2`, then `mem_tnew = 1`). Required: 2 consecutive stall cycles.
- Divide: pulse `ex_md_start = 1`, `ex_md_div = 1` in cycle 0, with `id_md_use = 1` held. Required: stall in cycles 0–10, release in cycle 11. Repeat with mult: stall in cycles 0–5.
- Saturation: set `CNT_W = 4` and stall for 20 cycles. Required: `stall_cycles` stops at 15. Then `cnt_clr = 1` together with `stall = 1`: required `stall_cycles = 0`.
